spi_flash_read_ctrl: RTL and testbench
======================================

SPI_FLASH_READ_CTRL -- requirements
Module: spi_flash_read_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter BYTE_NUM, default 148: data bytes read per transaction; legal range 1..255.
REQ-003 Parameter CS_GAP, default 8: cs_n high cycles after a transaction before IDLE; legal range 1..255.
REQ-004 clk  input  1  single system clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  one-cycle request to begin a read; sampled in IDLE only.
REQ-007 addr  input  24  flash start address; captured when start is accepted.
REQ-008 abort  input  1  terminates any active transaction.
REQ-009 spi_miso  input  1  flash serial data out; synchronised internally with two flops.
REQ-010 spi_cs_n  output  1  flash chip select, active-low.
REQ-011 spi_sclk  output  1  SPI clock, mode 0 (idle low).
REQ-012 spi_mosi  output  1  flash serial data in.
REQ-013 rd_data  output  8  last received byte, MSB first on the wire.
REQ-014 rd_valid  output  1  one-cycle strobe; rd_data is new.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when a non-aborted transaction completes.

Function
REQ-017 FSM states: IDLE, CMD, READ, GAP; all outputs are registered.
REQ-018 IDLE -> CMD when start=1 and abort=0; load shift register {8'h03, addr}; spi_cs_n=0 and spi_mosi=bit 31 from the next cycle.
REQ-019 start while busy=1 is ignored; a second start in the same transaction has no effect.
REQ-020 Half-period counter: counts 0..CLK_DIV-1 in CMD and READ, clears elsewhere; at terminal count spi_sclk toggles.
REQ-021 First SCLK rising edge occurs CLK_DIV cycles after spi_cs_n falls.
REQ-022 CMD: spi_mosi shifts to the next bit on each SCLK falling edge; 32 rising edges are counted.
REQ-023 CMD -> READ on the falling edge after the 32nd rising edge; spi_mosi held 0 in READ.
REQ-024 READ: synchronised miso is sampled into an 8-bit shift register on each SCLK rising edge, MSB first.
REQ-025 On the 8th rising edge of each byte, rd_data updates with the assembled byte the following cycle, with rd_valid=1 in that same cycle only.
REQ-026 Byte counter is 8 bits, cleared on entry to CMD, and incremented per byte; no wrap is possible within BYTE_NUM.
REQ-027 After byte BYTE_NUM, on the next SCLK falling edge: spi_sclk=0, spi_cs_n=1, -> GAP.
REQ-028 GAP: spi_cs_n=1 for exactly CS_GAP cycles; then -> IDLE with done=1 for one cycle, coincident with busy falling.
REQ-029 abort=1 in CMD or READ: next cycle spi_cs_n=1, spi_sclk=0, spi_mosi=0, -> GAP; no further rd_valid; done is suppressed at GAP exit.
REQ-030 abort in GAP restarts nothing and suppresses done; abort in IDLE has no effect; abort and start in the same IDLE cycle: start ignored.
REQ-031 A partial byte left by abort is discarded; rd_data keeps the last complete byte.

Reset
REQ-032 While rst_n=0 at a clk edge: state=IDLE; spi_cs_n=1, spi_sclk=0, spi_mosi=0, rd_data=8'h00, rd_valid=0, busy=0, done=0; all counters and shift registers cleared; miso sync flops=1.
REQ-033 Reset asserted mid-transaction takes effect at the next clk edge with no GAP period; start is accepted on the first cycle after rst_n returns high.

Verification
REQ-034 Use CLK_DIV=2, BYTE_NUM=4, CS_GAP=8; start with addr=24'h123456 -> mosi bits 0x03123456 MSB first, one bit per 4 clk; cs_n low for (32+32)*4 cycles.
REQ-035 Flash model returns A5,3C,FF,00 -> four rd_valid pulses with rd_data A5,3C,FF,00, spaced 32 clk; done after 8 cycles of cs_n high.
REQ-036 abort after the 2nd rd_valid -> cs_n high next cycle, no 3rd rd_valid, no done, busy low after 8 cycles, rd_data=3C.
REQ-037 start pulsed again during READ -> transaction unchanged; exactly 4 bytes and a single done.
REQ-038 rst_n low for 1 cycle during CMD -> all outputs at reset values next edge; a new start then completes normally.
REQ-039 BYTE_NUM=1, CLK_DIV=1 -> one rd_valid, sclk period 2 clk, done after 8 gap cycles.

Source files
------------

// File: rtl/spi_flash_read_ctrl.sv
// SPI flash read controller: sends opcode 0x03 plus a 24-bit address, then streams BYTE_NUM bytes.
// SCLK is mode 0; the miso sample strobe is delayed to line up with the two-flop synchroniser.
module spi_flash_read_ctrl #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned BYTE_NUM = 148,
  parameter int unsigned CS_GAP   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic        abort,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done
);
  localparam logic [7:0] DIV_TC    = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_TC    = 8'(CS_GAP - 1);
  localparam logic [7:0] BYTE_LAST = 8'(BYTE_NUM);

  typedef enum logic [1:0] {IDLE, CMD, READ, GAP} state_t;
  state_t state, state_d;

  logic [7:0]  div_cnt, div_cnt_d;
  logic [5:0]  bit_cnt, bit_cnt_d;
  logic [7:0]  byte_cnt, byte_cnt_d;
  logic [7:0]  gap_cnt, gap_cnt_d;
  logic [30:0] tx_sh, tx_sh_d;
  logic        aborted, aborted_d;
  logic        cs_n_d, sclk_d, mosi_d, busy_d, done_d, smp_d;
  logic [31:0] cmd_word;
  logic        div_tc, rise, fall, flush;
  logic        miso_p0, miso_p1, smp_p0, smp_p1;
  logic [6:0]  rx_sh;
  logic [2:0]  rx_cnt;

  assign cmd_word = {8'h03, addr};
  assign div_tc   = (div_cnt == DIV_TC);
  assign rise     = div_tc && !spi_sclk;
  assign fall     = div_tc && spi_sclk;
  assign flush    = abort && ((state == CMD) || (state == READ));

  always_comb begin
    state_d    = state;
    div_cnt_d  = '0;
    bit_cnt_d  = bit_cnt;
    byte_cnt_d = byte_cnt;
    gap_cnt_d  = gap_cnt;
    tx_sh_d    = tx_sh;
    aborted_d  = aborted;
    cs_n_d     = spi_cs_n;
    sclk_d     = spi_sclk;
    mosi_d     = spi_mosi;
    done_d     = 1'b0;
    smp_d      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d    = CMD;
          tx_sh_d    = cmd_word[30:0];
          mosi_d     = cmd_word[31];
          cs_n_d     = 1'b0;
          sclk_d     = 1'b0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          aborted_d  = 1'b0;
        end
      end
      CMD, READ: begin
        if (abort) begin
          state_d   = GAP;
          cs_n_d    = 1'b1;
          sclk_d    = 1'b0;
          mosi_d    = 1'b0;
          gap_cnt_d = '0;
          aborted_d = 1'b1;
        end else begin
          div_cnt_d = div_tc ? 8'd0 : div_cnt + 8'd1;
          if (div_tc) sclk_d = !spi_sclk;
          if (rise) begin
            if (state == CMD) begin
              bit_cnt_d = bit_cnt + 6'd1;
            end else begin
              smp_d = 1'b1;
              if (bit_cnt == 6'd7) begin
                bit_cnt_d  = '0;
                byte_cnt_d = byte_cnt + 8'd1;
              end else begin
                bit_cnt_d = bit_cnt + 6'd1;
              end
            end
          end
          if (fall) begin
            if (state == CMD) begin
              if (bit_cnt == 6'd32) begin
                state_d   = READ;
                bit_cnt_d = '0;
                mosi_d    = 1'b0;
              end else begin
                mosi_d  = tx_sh[30];
                tx_sh_d = {tx_sh[29:0], 1'b0};
              end
            end else if (byte_cnt == BYTE_LAST) begin
              state_d   = GAP;
              cs_n_d    = 1'b1;
              sclk_d    = 1'b0;
              div_cnt_d = '0;
              gap_cnt_d = '0;
            end
          end
        end
      end
      GAP: begin
        if (abort) aborted_d = 1'b1;
        if (gap_cnt == GAP_TC) begin
          state_d = IDLE;
          done_d  = !(aborted || abort);
        end else begin
          gap_cnt_d = gap_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      tx_sh    <= '0;
      aborted  <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_cnt_d;
      bit_cnt  <= bit_cnt_d;
      byte_cnt <= byte_cnt_d;
      gap_cnt  <= gap_cnt_d;
      tx_sh    <= tx_sh_d;
      aborted  <= aborted_d;
      spi_cs_n <= cs_n_d;
      spi_sclk <= sclk_d;
      spi_mosi <= mosi_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // p0/p1: miso synchroniser and the matching two-cycle delay of the rising-edge sample strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso_p0  <= 1'b1;
      miso_p1  <= 1'b1;
      smp_p0   <= 1'b0;
      smp_p1   <= 1'b0;
      rx_sh    <= '0;
      rx_cnt   <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      miso_p0  <= spi_miso;
      miso_p1  <= miso_p0;
      rd_valid <= 1'b0;
      if (flush) begin
        smp_p0 <= 1'b0;
        smp_p1 <= 1'b0;
        rx_cnt <= '0;
      end else begin
        smp_p0 <= smp_d;
        smp_p1 <= smp_p0;
        if (smp_p1) begin
          rx_sh  <= {rx_sh[5:0], miso_p1};
          rx_cnt <= rx_cnt + 3'd1;
          if (rx_cnt == 3'd7) begin
            rd_data  <= {rx_sh, miso_p1};
            rd_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Bench for spi_flash_read_ctrl: two instances (CLK_DIV=2/BYTE_NUM=4 and CLK_DIV=1/BYTE_NUM=1)
// talk to a behavioural mode-0 flash; results are compared with values derived from the protocol rules.
`timescale 1ns/1ps
module tb_spi_flash_read_ctrl;
  localparam int G = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [2];
  logic        abort [2];
  logic [23:0] addr [2];
  logic        miso [2];
  logic        cs_n [2], sclk [2], mosi [2], rd_valid [2], busy [2], done [2];
  logic [7:0]  rd_data [2];

  spi_flash_read_ctrl #(.CLK_DIV(2), .BYTE_NUM(4), .CS_GAP(G)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .addr(addr[0]), .abort(abort[0]),
    .spi_miso(miso[0]), .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .busy(busy[0]), .done(done[0]));

  spi_flash_read_ctrl #(.CLK_DIV(1), .BYTE_NUM(1), .CS_GAP(G)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .addr(addr[1]), .abort(abort[1]),
    .spi_miso(miso[1]), .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .busy(busy[1]), .done(done[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash contents and per-instance observation state
  logic [7:0]  mem [256];
  logic [31:0] cmd_sh [2];
  logic [7:0]  got [2][16];
  int          vld_cyc [2][16];
  int          rises [2], got_n [2], cs_low [2], done_n [2], proto_err [2];
  int          cs_fall_cyc [2], cs_rise_cyc [2], done_cyc [2], bfall_cyc [2], last_rise [2];
  logic        p_sclk [2], p_cs [2], p_busy [2];
  logic        clr_tog [2], clr_seen [2];

  int checks = 0;
  int failures = 0;

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int nbytes_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  always @(negedge clk) begin
    int idx;
    logic [23:0] a;
    for (int i = 0; i < 2; i++) begin
      if (clr_seen[i] != clr_tog[i]) begin
        clr_seen[i] = clr_tog[i];
        got_n[i] = 0; cs_low[i] = 0; done_n[i] = 0; proto_err[i] = 0;
        done_cyc[i] = -1; bfall_cyc[i] = -2; cs_rise_cyc[i] = -3;
      end
      if (!cs_n[i] && p_cs[i]) cs_fall_cyc[i] = cyc;
      if (cs_n[i] && !p_cs[i]) cs_rise_cyc[i] = cyc;
      if (!cs_n[i]) cs_low[i]++;
      if (cs_n[i]) begin
        rises[i] = 0;
        miso[i] = 1'b1;
        if (sclk[i] || mosi[i]) proto_err[i]++;
      end else if (sclk[i] && !p_sclk[i]) begin
        if (rises[i] < 32) cmd_sh[i] = {cmd_sh[i][30:0], mosi[i]};
        if (rises[i] == 0 && (cyc - cs_fall_cyc[i]) != div_of(i)) proto_err[i]++;
        if (rises[i] > 0 && (cyc - last_rise[i]) != 2 * div_of(i)) proto_err[i]++;
        last_rise[i] = cyc;
        rises[i]++;
      end else if (!sclk[i] && p_sclk[i] && rises[i] >= 32) begin
        idx = rises[i] - 32;
        a = cmd_sh[i][23:0] + 24'(idx / 8);
        miso[i] = mem[a[7:0]][3'(7 - (idx % 8))];
      end
      if (!cs_n[i] && rises[i] >= 33 && mosi[i]) proto_err[i]++;
      if (rd_valid[i]) begin
        if (got_n[i] < 16) begin
          got[i][got_n[i]] = rd_data[i];
          vld_cyc[i][got_n[i]] = cyc;
        end
        got_n[i]++;
      end
      if (done[i]) begin
        done_n[i]++;
        done_cyc[i] = cyc;
      end
      if (!busy[i] && p_busy[i]) bfall_cyc[i] = cyc;
      p_sclk[i] = sclk[i];
      p_cs[i]   = cs_n[i];
      p_busy[i] = busy[i];
    end
  end

  task automatic chk(input string tag, input int i, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input int i, input logic [23:0] a);
    clr_tog[i] = ~clr_tog[i];
    addr[i]  = a;
    start[i] = 1'b1;
    tick(1);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (done_n[i] == 0 && n < 5000) begin
      tick(1);
      n++;
    end
    chk("done_seen", i, done_n[i] != 0, 1);
    tick(2);
  endtask

  task automatic wait_got(input int i, input int k);
    int n = 0;
    while (got_n[i] < k && n < 5000) begin
      tick(1);
      n++;
    end
    chk("byte_wait", i, got_n[i] >= k, 1);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 5000) begin
      tick(1);
      n++;
    end
    chk("idle_wait", i, busy[i], 0);
  endtask

  task automatic check_reset(input int i);
    chk("rst_cs_n", i, cs_n[i], 1);
    chk("rst_sclk", i, sclk[i], 0);
    chk("rst_mosi", i, mosi[i], 0);
    chk("rst_rd_data", i, rd_data[i], 0);
    chk("rst_rd_valid", i, rd_valid[i], 0);
    chk("rst_busy", i, busy[i], 0);
    chk("rst_done", i, done[i], 0);
  endtask

  task automatic check_txn(input int i, input logic [23:0] a);
    int n = nbytes_of(i);
    int d = div_of(i);
    logic [23:0] aj;
    chk("cmd_word", i, cmd_sh[i], {8'h03, a});
    chk("byte_count", i, got_n[i], n);
    for (int j = 0; j < n; j++) begin
      aj = a + 24'(j);
      chk("byte", i, got[i][j], mem[aj[7:0]]);
    end
    for (int j = 1; j < n; j++) chk("byte_spacing", i, vld_cyc[i][j] - vld_cyc[i][j-1], 16 * d);
    chk("cs_low_cycles", i, cs_low[i], (32 + 8 * n) * 2 * d);
    chk("done_count", i, done_n[i], 1);
    chk("gap_cycles", i, done_cyc[i] - cs_rise_cyc[i], G);
    chk("done_busy_align", i, bfall_cyc[i] - cs_rise_cyc[i], G);
    chk("protocol", i, proto_err[i], 0);
    aj = a + 24'(n - 1);
    chk("rd_data_last", i, rd_data[i], mem[aj[7:0]]);
  endtask

  initial begin
    logic [23:0] ra;
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    mem[8'h56] = 8'hA5;
    mem[8'h57] = 8'h3C;
    mem[8'h58] = 8'hFF;
    mem[8'h59] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; addr[i] = '0; clr_tog[i] = 1'b0;
    end
    rst_n = 1'b0;
    tick(3);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    tick(2);

    // start and abort together in IDLE: start must be ignored
    start[0] = 1'b1; abort[0] = 1'b1; addr[0] = 24'h123456;
    tick(1);
    start[0] = 1'b0; abort[0] = 1'b0;
    chk("start_abort_busy", 0, busy[0], 0);
    tick(3);
    chk("start_abort_cs", 0, cs_n[0], 1);

    // directed read at 0x123456: A5 3C FF 00
    go(0, 24'h123456);
    wait_done(0);
    check_txn(0, 24'h123456);
    chk("byte0_const", 0, got[0][0], 8'hA5);
    chk("byte3_const", 0, got[0][3], 8'h00);

    // second start while reading is ignored
    go(0, 24'h123456);
    wait_got(0, 1);
    start[0] = 1'b1; addr[0] = 24'hABCDEF;
    tick(1);
    start[0] = 1'b0;
    wait_done(0);
    check_txn(0, 24'h123456);
    tick(40);
    chk("no_restart_done", 0, done_n[0], 1);
    chk("no_restart_busy", 0, busy[0], 0);

    // abort after the second byte
    go(0, 24'h123456);
    wait_got(0, 2);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    chk("abort_cs_n", 0, cs_n[0], 1);
    chk("abort_sclk", 0, sclk[0], 0);
    chk("abort_mosi", 0, mosi[0], 0);
    chk("abort_busy_gap", 0, busy[0], 1);
    tick(7);
    chk("abort_busy_end", 0, busy[0], 1);
    tick(1);
    chk("abort_busy_low", 0, busy[0], 0);
    tick(40);
    chk("abort_bytes", 0, got_n[0], 2);
    chk("abort_no_done", 0, done_n[0], 0);
    chk("abort_rd_data", 0, rd_data[0], 8'h3C);

    // abort during GAP suppresses done only
    ra = 24'($urandom);
    go(0, ra);
    begin
      int n = 0;
      while (!cs_n[0] && n < 5000) begin tick(1); n++; end
    end
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    wait_idle(0);
    tick(3);
    chk("gap_abort_bytes", 0, got_n[0], 4);
    chk("gap_abort_no_done", 0, done_n[0], 0);
    chk("gap_abort_len", 0, bfall_cyc[0] - cs_rise_cyc[0], G);

    // one-cycle reset in CMD, then start on the first cycle after release
    go(0, 24'h123456);
    tick(10);
    rst_n = 1'b0;
    tick(1);
    check_reset(0);
    rst_n = 1'b1;
    ra = 24'($urandom);
    clr_tog[0] = ~clr_tog[0];
    addr[0] = ra;
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    chk("post_reset_busy", 0, busy[0], 1);
    wait_done(0);
    check_txn(0, ra);

    // random addresses on the default-style instance
    for (int t = 0; t < 3; t++) begin
      ra = 24'($urandom);
      go(0, ra);
      wait_done(0);
      check_txn(0, ra);
    end

    // single-byte instance with the fastest SCLK
    go(1, 24'h000056);
    wait_done(1);
    check_txn(1, 24'h000056);
    chk("fast_byte_const", 1, got[1][0], 8'hA5);
    for (int t = 0; t < 3; t++) begin
      ra = 24'($urandom);
      go(1, ra);
      wait_done(1);
      check_txn(1, ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
